dft_sample_feeder: RTL and testbench

DFT_SAMPLE_FEEDER -- requirements
Module: dft_sample_feeder

---
 rtl/dft_sample_feeder.sv | 119 +++++++++++
 tb/tb_dft_sample_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_sample_feeder.sv
// rtl/dft_sample_feeder.sv - sample FIFO with a paced issue FSM feeding a DFT core
// Samples are queued, then issued one per pop with frame index and start/end markers.
module dft_sample_feeder #(
  parameter  int WIDTH     = 12,
  parameter  int N_MAX     = 8,
  parameter  int DEPTH     = 8,
  localparam int LOG_N_MAX = $clog2(N_MAX),
  localparam int LN_W      = $clog2(LOG_N_MAX) + 1,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_dft_ready,
  input  logic [15:0]          i_gap,
  input  logic [LN_W-1:0]      i_log_n,
  output logic [WIDTH-1:0]     o_x,
  output logic                 o_wr,
  output logic [LOG_N_MAX:0]   o_n,
  output logic                 o_frame_start,
  output logic                 o_frame_end,
  output logic [LVL_W-1:0]     o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]   LVL_ONE   = LVL_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [LN_W-1:0]    LOG_CLAMP = LN_W'(LOG_N_MAX);
  localparam logic [LOG_N_MAX:0] IDX_ONE   = {{LOG_N_MAX{1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [15:0]        gap_cnt;
  logic [LOG_N_MAX:0] idx, last_idx;
  logic [LN_W-1:0]    n_log, log_sel;
  logic               push, pop, idx_zero, at_last;

  assign o_ready = (o_level < LVL_FULL);
  assign push    = i_valid && o_ready && !i_sys_rst;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (o_level != '0 && i_dft_ready) state_nxt = GAP;
    end else begin
      if (gap_cnt == '0 && i_dft_ready) state_nxt = IDLE;
    end
  end

  always_comb begin
    pop = (state == IDLE) && (o_level != '0) && i_dft_ready;
  end

  // Frame length is latched only on the first sample of a frame, clamped to N_MAX.
  always_comb begin
    idx_zero = (idx == '0);
    log_sel  = n_log;
    if (idx_zero) log_sel = (i_log_n > LOG_CLAMP) ? LOG_CLAMP : i_log_n;
    last_idx = (IDX_ONE << log_sel) - IDX_ONE;
    at_last  = (idx == last_idx);
  end

  always_ff @(posedge i_sys_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      o_level <= o_level + LVL_ONE;
      else if (!push && pop) o_level <= o_level - LVL_ONE;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst)                          gap_cnt <= '0;
    else if (pop)                           gap_cnt <= i_gap;
    else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      o_x           <= '0;
      o_wr          <= 1'b0;
      o_n           <= '0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      idx           <= '0;
      n_log         <= '0;
    end else begin
      o_wr          <= pop;
      o_frame_start <= pop && idx_zero;
      o_frame_end   <= pop && at_last;
      if (pop) begin
        o_x <= mem[rd_ptr];
        o_n <= idx;
        idx <= at_last ? '0 : idx + IDX_ONE;
        if (idx_zero) n_log <= log_sel;
      end
    end
  end

endmodule

// File: tb/tb_dft_sample_feeder.sv
// tb/tb_dft_sample_feeder.sv - self-checking bench for dft_sample_feeder
// A queue-based model checks every issued sample; directed sequences cover latency, pacing, full, stall, reset.
module tb_dft_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        valid;
  logic        ready_o;
  logic        dft_ready;
  logic [15:0] gap;
  logic [2:0]  log_n;
  logic [11:0] x;
  logic        wr;
  logic [3:0]  n;
  logic        fs, fe;
  logic [3:0]  level;

  always #5 clk = ~clk;

  dft_sample_feeder #(.WIDTH(12), .N_MAX(8), .DEPTH(8)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_data(din), .i_valid(valid), .o_ready(ready_o),
    .i_dft_ready(dft_ready), .i_gap(gap), .i_log_n(log_n), .o_x(x), .o_wr(wr), .o_n(n),
    .o_frame_start(fs), .o_frame_end(fe), .o_level(level)
  );

  typedef struct {
    int log_n;
    int cnt;
    int starts;
    int ends;
    int last_n;
  } vec_t;

  int total = 0, bad = 0, cyc = 0;
  logic [11:0] exp_q[$];
  int m_idx = 0, m_n = 1, last_wr = -1;
  int wr_cnt = 0, start_cnt = 0, end_cnt = 0, last_n = 0, acc_cyc = 0;
  int wr_cyc[$];
  int wr_n[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model: issued samples follow acceptance order; index counts pops modulo 2^min(log_n,3).
  always @(negedge clk) begin : mon
    logic [11:0] e;
    int ln;
    if (wr) begin
      if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        e = exp_q.pop_front();
        if (m_idx == 0) begin
          ln  = (int'(log_n) > 3) ? 3 : int'(log_n);
          m_n = 1 << ln;
        end
        chk("x", x, e);
        chk("n", n, m_idx);
        chk("start", fs, m_idx == 0);
        chk("end", fe, m_idx == m_n - 1);
        m_idx = (m_idx + 1) % m_n;
      end
      if (last_wr >= 0) chk("spacing_min", (cyc - last_wr) >= int'(gap) + 2, 1);
      last_wr = cyc;
      wr_cnt++;
      start_cnt += int'(fs);
      end_cnt += int'(fe);
      last_n = int'(n);
      wr_cyc.push_back(cyc);
      wr_n.push_back(int'(n));
    end else begin
      chk("flags_without_wr", {fs, fe}, 0);
    end
    chk("ready_vs_level", ready_o, level < 4'd8);
    chk("level", level, exp_q.size());
    if (rst) begin
      exp_q.delete();
      m_idx   = 0;
      last_wr = -1;
    end else if (valid && ready_o) begin
      exp_q.push_back(din);
    end
  end

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b1;
    din   = 12'hFFF;
    step(2);
    @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_level", level, 0);
    chk("rst_wr", wr, 0);
    chk("rst_x", x, 0);
    chk("rst_n", n, 0);
    chk("rst_flags", {fs, fe}, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    valid     = 1'b0;
    wr_cnt    = 0;
    start_cnt = 0;
    end_cnt   = 0;
    last_n    = 0;
    wr_cyc.delete();
    wr_n.delete();
  endtask

  task automatic push(input logic [11:0] d);
    int  k  = 0;
    bit  ok = 1'b0;
    valid = 1'b1;
    din   = d;
    while (!ok && k < 3000) begin
      @(negedge clk);
      ok = ready_o && !rst;
      if (ok) acc_cyc = cyc;
      @(posedge clk);
      #1;
      k++;
    end
    valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_wr(input string name);
    int k = 0;
    @(negedge clk);
    while (!wr && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, wr, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (level != 4'd0 && k < 5000) begin
      step();
      k++;
    end
    chk("drain", level, 0);
    step(int'(gap) + 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   a, cnt, accepted, k;

    tbl[0] = '{0, 3, 3, 3, 0};
    tbl[1] = '{1, 5, 3, 2, 0};
    tbl[2] = '{2, 6, 2, 1, 1};
    tbl[3] = '{3, 8, 1, 1, 7};
    tbl[4] = '{7, 8, 1, 1, 7};
    tbl[5] = '{5, 10, 2, 1, 1};
    tbl[6] = '{4, 3, 1, 0, 2};

    rst = 1'b1; valid = 1'b0; din = '0; dft_ready = 1'b1; gap = '0; log_n = 3'd3;
    do_reset();

    push(12'd5);
    a = acc_cyc;
    wait_wr("single_wr");
    chk("single_latency", cyc - a, 2);
    chk("single_x", x, 5);
    chk("single_n", n, 0);
    @(negedge clk);
    chk("single_pulse_width", wr, 0);
    drain();

    for (int i = 0; i < 7; i++) begin
      do_reset();
      log_n = 3'(tbl[i].log_n);
      gap = '0;
      dft_ready = 1'b1;
      for (int j = 0; j < tbl[i].cnt; j++) push(12'($urandom));
      drain();
      chk("tbl_starts", start_cnt, tbl[i].starts);
      chk("tbl_ends", end_cnt, tbl[i].ends);
      chk("tbl_last_n", last_n, tbl[i].last_n);
    end

    do_reset();
    log_n = 3'd3;
    gap = 16'd57;
    for (int i = 0; i < 9; i++) push(12'(i % 2));
    drain();
    chk("frame_pulses", wr_cyc.size(), 9);
    if (wr_cyc.size() == 9) begin
      for (int i = 1; i < 9; i++) chk("frame_spacing", wr_cyc[i] - wr_cyc[i-1], 59);
      chk("frame_n_wrap", wr_n[8], 0);
    end
    chk("frame_starts", start_cnt, 2);
    chk("frame_ends", end_cnt, 1);

    do_reset();
    gap = '0;
    dft_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1;
      din = 12'(100 + i);
      @(negedge clk);
      if (ready_o) accepted++;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    chk("full_accepted", accepted, 8);
    @(negedge clk);
    chk("full_level", level, 8);
    chk("full_ready", ready_o, 0);
    @(posedge clk);
    #1;
    dft_ready = 1'b1;
    drain();
    chk("full_issued", wr_cnt, 8);
    chk("full_ready_back", ready_o, 1);

    do_reset();
    gap = 16'd10;
    log_n = 3'd2;
    for (int i = 0; i < 4; i++) push(12'(300 + i));
    wait_wr("stall_first");
    @(posedge clk);
    #1;
    dft_ready = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr) cnt++;
      @(posedge clk);
      #1;
    end
    dft_ready = 1'b1;
    chk("stall_no_wr", cnt, 0);
    drain();
    chk("stall_issued", wr_cnt, 4);

    do_reset();
    log_n = 3'd3;
    gap = 16'd3;
    for (int i = 0; i < 7; i++) push(12'(200 + i));
    k = 0;
    while (wr_cnt < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("mid_frame_wrs", wr_cnt, 3);
    chk("mid_frame_level", level, 4);
    @(posedge clk);
    #1;
    do_reset();
    push(12'h0AB);
    a = acc_cyc;
    wait_wr("post_rst_wr");
    chk("post_rst_latency", cyc - a, 2);
    chk("post_rst_n", n, 0);
    chk("post_rst_start", fs, 1);
    chk("post_rst_x", x, 12'h0AB);
    drain();

    for (int r = 0; r < 2; r++) begin
      do_reset();
      gap = 16'($urandom_range(0, 4));
      log_n = 3'($urandom_range(0, 7));
      repeat (600) begin
        valid = 1'($urandom_range(0, 1));
        din = 12'($urandom);
        dft_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      valid = 1'b0;
      dft_ready = 1'b1;
      drain();
      chk("rand_empty", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
